tflaf_stream_shell: RTL and testbench
=====================================

# tflaf_stream_shell

Streaming front/back end for the TFLAF adaptive filter core. Accepts (signal, desired) sample pairs over a ready/valid interface and drives the core's free-running sample inputs and `ip_valid`. After the core's fixed pipeline latency it captures `filter_out_d`/`error_d` and returns them over a ready/valid result interface with backpressure. Credit-based issue control guarantees that no in-flight result is ever dropped, even though the core itself cannot stall.

## Interface
Parameters:
- `WIDTH`, 16 — sample/result width (Q-format with `QP` fractional bits; pass-through only).
- `LAT`, 8 — cycles from `f_valid` high at the core input to the matching `f_out`/`f_error` being valid at the core output. Set at integration; 1 ≤ `LAT` < `DEPTH`.
- `DEPTH`, 16 — result FIFO entries; power of two, ≥ 2.

Ports:
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — asynchronous, active-low (asserted at 0). Deassertion is synchronous to `clk` at integration level.
- `s_valid` in 1 — input pair valid.
- `s_ready` out 1 — shell can accept a pair.
- `s_signal` in `WIDTH` — input sample x(n).
- `s_desired` in `WIDTH` — desired sample d(n).
- `f_signal` out `WIDTH` — to core `signal_in`.
- `f_desired` out `WIDTH` — to core `desired_in`.
- `f_valid` out 1 — to core `ip_valid`.
- `f_out` in `WIDTH` — from core `filter_out_d`.
- `f_error` in `WIDTH` — from core `error_d`.
- `m_valid` out 1 — result valid.
- `m_ready` in 1 — result consumer ready.
- `m_out` out `WIDTH` — filter output y(n).
- `m_error` out `WIDTH` — error e(n).
- `ovf` out 1 — sticky: a capture occurred with the FIFO full (design error).

## Operation
- Accept on `s_valid && s_ready`. In the same cycle, drive `f_signal`, `f_desired` and `f_valid=1` combinationally from `s_*`. In any other cycle drive `f_signal=0`, `f_desired=0`, `f_valid=0`. The core clocks every cycle, so zeros enter its tap line during gaps.
- `inflight` counter (0..`LAT`): +1 on accept, −1 on capture; both in one cycle → unchanged.
- `s_ready = (fifo_count + inflight) < DEPTH`. It is registered-free combinational from counters only and never depends on `s_valid`.
- Valid tracker: `LAT`-bit shift register fed by `f_valid`. When its output bit is 1, capture `{f_out, f_error}` into the FIFO in that cycle.
- FIFO: `DEPTH` entries, read/write pointers with one extra wrap bit; full when MSBs differ and the rest are equal, empty when pointers are equal.
  - Simultaneous push and pop is legal when full (the pop frees the slot) and when empty (the push lands, and `m_valid` rises the next cycle).
- `m_valid = !empty`; `m_out`/`m_error` come from the head entry. Pop on `m_valid && m_ready`.
- Capture while full and not popping: drop the sample and set `ovf=1` until reset. The credit rule makes this unreachable.

## Timing
- Reset values: `s_ready=1`, `f_valid=0`, `f_signal=0`, `f_desired=0`, `m_valid=0`, `m_out=0`, `m_error=0`, `ovf=0`. Counters, pointers and the tracker are cleared.
- Reset mid-operation: all in-flight and queued results are discarded. The core's own reset must be applied in the same window.
- Accept at cycle t → capture at t+`LAT` → `m_valid` at t+`LAT`+1 at the earliest.
- Sustained throughput is one pair per cycle when `m_ready=1` throughout.
- `m_valid`/`m_out`/`m_error` hold stable while `m_valid && !m_ready`.

## Structure
- Shared package `tflaf_pkg`: `WIDTH`/`QP` defaults and the `LAT` value computed for the default `L_ORD=4`, `Q_ORD=7` core, so the shell and the top-level agree.
- One sub-module: `sync_fifo_fwft`, parameters `WIDTH`=2·`WIDTH`, `DEPTH`. It exposes `count`, with asynchronous active-low reset. The `pipeline`/`DelayNUnit` style delay cannot be reused for the tracker because of the reset polarity; implement the tracker inline.

## Test plan
- Reset: hold `reset=0` for 3 cycles → all outputs at their reset values; `s_ready=1` on release.
- Single pair `s_signal=16'h0800`, `s_desired=16'h0400` at cycle 10, core stub = `LAT`=8 delay line → `m_valid` at cycle 19 with `m_out`/`m_error` equal to the stub's delayed data.
- Streaming of 100 pairs with `m_ready=1` → 100 results in order with no gaps after the first; `s_ready` stays 1.
- `m_ready=0` with continuous `s_valid` → `s_ready` falls once `fifo_count+inflight=16`. Exactly 16 results are queued, `ovf=0`. Release `m_ready` → all 16 drain in order.
- Simultaneous push and pop at full and at empty → count is unchanged or correct; no loss or duplication; pointer wrap verified over 3×`DEPTH` transfers.
- Async `reset` asserted mid-stream, between clock edges → outputs clear immediately; after release, a fresh stream of 4 results is correct.

Source files
------------

// File: rtl/tflaf_stream_shell_pkg.sv
// Shared TFLAF constants: sample format defaults and the core pipeline latency
// derived from the default filter orders, so the shell and the top level agree.
package tflaf_pkg;

    localparam int TFLAF_WIDTH = 16;
    localparam int TFLAF_QP    = 12;
    localparam int TFLAF_L_ORD = 4;
    localparam int TFLAF_Q_ORD = 7;
    localparam int TFLAF_DEPTH = 16;

    // Core latency: input and output registers (2), linear tap adder tree,
    // quadratic term adder tree, and the final error subtract stage (1).
    function automatic int tflaf_core_lat(input int l_ord, input int q_ord);
        return 2 + $clog2(l_ord) + $clog2(q_ord + 1) + 1;
    endfunction

    localparam int TFLAF_LAT = tflaf_core_lat(TFLAF_L_ORD, TFLAF_Q_ORD);

endpackage

// File: rtl/tflaf_stream_shell_fifo.sv
// First-word-fall-through synchronous FIFO holding captured {y, e} results.
// Pointers carry one extra wrap bit; the head entry is visible whenever the
// FIFO is non-empty and reads as zero while empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             push_en_s;
    logic             pop_en_s;

    // Status flags, head data and the accepted push/pop strobes.
    always_comb begin
        full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        empty     = (wr_ptr_r == rd_ptr_r);
        count     = wr_ptr_r - rd_ptr_r;
        pop_en_s  = pop && !empty;
        // A pop in the same cycle frees the slot, so push at full is legal then.
        push_en_s = push && (!full || pop_en_s);
        if (empty) begin
            pop_data = {WIDTH{1'b0}};
        end else begin
            pop_data = mem_r[rd_ptr_r[AW-1:0]];
        end
    end

    // Storage array write; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (push_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

    // Read/write pointer advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/tflaf_stream_shell.sv
// Streaming shell around the non-stallable TFLAF core. Pairs are issued to the
// core only while there is a guaranteed FIFO slot for their result, counting
// both queued results and results still inside the core pipeline.
import tflaf_pkg::*;

module tflaf_stream_shell #(
    parameter int WIDTH = TFLAF_WIDTH,
    parameter int LAT   = TFLAF_LAT,
    parameter int DEPTH = TFLAF_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_signal,
    input  logic [WIDTH-1:0] s_desired,
    output logic [WIDTH-1:0] f_signal,
    output logic [WIDTH-1:0] f_desired,
    output logic             f_valid,
    input  logic [WIDTH-1:0] f_out,
    input  logic [WIDTH-1:0] f_error,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_out,
    output logic [WIDTH-1:0] m_error,
    output logic             ovf
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW:0]   CREDIT_LIM = (CW+1)'(DEPTH);

    logic                 accept_s;
    logic                 capture_s;
    logic                 pop_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [CW-1:0]        fifo_count_s;
    logic [2*WIDTH-1:0]   fifo_head_s;
    logic [CW:0]          credit_sum_s;
    logic [CW-1:0]        inflight_r;
    logic [LAT-1:0]       trk_r;
    logic                 ovf_r;

    // Credit check and accept strobe; reset gating keeps the core input quiet
    // while the shell is held in reset.
    always_comb begin
        credit_sum_s = {1'b0, fifo_count_s} + {1'b0, inflight_r};
        s_ready      = (credit_sum_s < CREDIT_LIM);
        accept_s     = s_valid && s_ready && reset;
        capture_s    = trk_r[LAT-1];
        pop_s        = !fifo_empty_s && m_ready;
    end

    // Core input drive: the sample pair on accept, zeros in every gap cycle.
    always_comb begin
        if (accept_s) begin
            f_valid   = 1'b1;
            f_signal  = s_signal;
            f_desired = s_desired;
        end else begin
            f_valid   = 1'b0;
            f_signal  = {WIDTH{1'b0}};
            f_desired = {WIDTH{1'b0}};
        end
    end

    // Results issued to the core but not yet captured.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_r <= {CW{1'b0}};
        end else begin
            case ({accept_s, capture_s})
                2'b10:   inflight_r <= inflight_r + CNT_ONE;
                2'b01:   inflight_r <= inflight_r - CNT_ONE;
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // Valid tracker mirroring the core pipeline depth.
    generate
        if (LAT == 1) begin : g_trk_single
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    trk_r <= 1'b0;
                end else begin
                    trk_r <= accept_s;
                end
            end
        end else begin : g_trk_shift
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    trk_r <= {LAT{1'b0}};
                end else begin
                    trk_r <= {trk_r[LAT-2:0], accept_s};
                end
            end
        end
    endgenerate

    // Sticky overflow: a capture found no free slot and was dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_r <= 1'b0;
        end else if (capture_s && fifo_full_s && !pop_s) begin
            ovf_r <= 1'b1;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (capture_s),
        .push_data ({f_out, f_error}),
        .pop       (pop_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Result interface taken from the FIFO head.
    always_comb begin
        m_valid = !fifo_empty_s;
        m_out   = fifo_head_s[2*WIDTH-1:WIDTH];
        m_error = fifo_head_s[WIDTH-1:0];
        ovf     = ovf_r;
    end

endmodule

// File: tb/tb_tflaf_stream_shell.sv
// Bench for tflaf_stream_shell with an LAT-deep delay-line core stub that
// returns y = x + d and e = d - x.
module tb_tflaf_stream_shell;

    localparam int W     = 16;
    localparam int LAT   = 8;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_signal;
    logic [W-1:0] s_desired;
    logic [W-1:0] f_signal;
    logic [W-1:0] f_desired;
    logic         f_valid;
    logic [W-1:0] f_out;
    logic [W-1:0] f_error;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_out;
    logic [W-1:0] m_error;
    logic         ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    tflaf_stream_shell #(.WIDTH(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_signal  (s_signal),
        .s_desired (s_desired),
        .f_signal  (f_signal),
        .f_desired (f_desired),
        .f_valid   (f_valid),
        .f_out     (f_out),
        .f_error   (f_error),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_out     (m_out),
        .m_error   (m_error),
        .ovf       (ovf)
    );

    // Core stub: pure LAT-stage delay line, no reset, clocks every cycle.
    logic [W-1:0] d_sig [LAT];
    logic [W-1:0] d_des [LAT];
    always @(posedge clk) begin
        d_sig[0] <= f_signal;
        d_des[0] <= f_desired;
        for (int i = 1; i < LAT; i++) begin
            d_sig[i] <= d_sig[i-1];
            d_des[i] <= d_des[i-1];
        end
    end
    assign f_out   = d_sig[LAT-1] + d_des[LAT-1];
    assign f_error = d_des[LAT-1] - d_sig[LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] pair_sig(input int i);
        return W'(i * 257 + 17);
    endfunction
    function automatic logic [W-1:0] pair_des(input int i);
        return W'(i * 55);
    endfunction

    // Scoreboard monitor: handshakes observed mid-cycle, ahead of the next edge.
    logic [31:0] exp_q [$];
    logic        mon_en = 1'b0;
    int          recv_cnt = 0;
    int          acc_cnt  = 0;
    int          first_cyc = 0;
    int          last_cyc  = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", {m_out, m_error}, 32'h0);
                    if ({m_out, m_error} == 32'h0) begin
                        bad++;
                        $display("FAIL unexpected_result: got zero result with empty scoreboard");
                    end
                end else begin
                    chk("stream_result", {m_out, m_error}, exp_q.pop_front());
                end
                if (recv_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                recv_cnt++;
            end
            if (s_valid && s_ready) begin
                exp_q.push_back({s_signal + s_desired, s_desired - s_signal});
                acc_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_recv(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (recv_cnt < target && n < budget) begin
            step();
            n++;
        end
        chk(name, 32'(recv_cnt), 32'(target));
    endtask

    typedef struct {
        logic [W-1:0] sig;
        logic [W-1:0] des;
        logic [W-1:0] exp_out;
        logic [W-1:0] exp_err;
    } vec_t;
    vec_t tbl [6];

    initial begin
        int n;
        int base;
        int idx;
        logic hs;
        logic [31:0] held;

        tbl[0] = '{16'h0800, 16'h0400, 16'h0C00, 16'hFC00};
        tbl[1] = '{16'h0001, 16'h0002, 16'h0003, 16'h0001};
        tbl[2] = '{16'h7FFF, 16'h0001, 16'h8000, 16'h8002};
        tbl[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0000};
        tbl[4] = '{16'h1234, 16'h0000, 16'h1234, 16'hEDCC};
        tbl[5] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};

        // Reset held for 3 cycles with a pair offered at the input.
        reset = 1'b0; m_ready = 1'b1;
        s_valid = 1'b1; s_signal = 16'hAAAA; s_desired = 16'h5555;
        repeat (3) step();
        chk("rst_s_ready",   32'(s_ready),   32'h1);
        chk("rst_f_valid",   32'(f_valid),   32'h0);
        chk("rst_f_signal",  32'(f_signal),  32'h0);
        chk("rst_f_desired", 32'(f_desired), 32'h0);
        chk("rst_m_valid",   32'(m_valid),   32'h0);
        chk("rst_m_out",     32'(m_out),     32'h0);
        chk("rst_m_error",   32'(m_error),   32'h0);
        chk("rst_ovf",       32'(ovf),       32'h0);
        s_valid = 1'b0;
        reset = 1'b1;
        step();
        chk("release_s_ready", 32'(s_ready), 32'h1);

        // Single-pair latency and pass-through vectors.
        for (int v = 0; v < 6; v++) begin
            s_valid = 1'b1; s_signal = tbl[v].sig; s_desired = tbl[v].des;
            #1;
            chk("vec_s_ready",  32'(s_ready),  32'h1);
            chk("vec_f_valid",  32'(f_valid),  32'h1);
            chk("vec_f_signal", 32'(f_signal), 32'(tbl[v].sig));
            chk("vec_f_desired", 32'(f_desired), 32'(tbl[v].des));
            step();
            s_valid = 1'b0;
            #1;
            chk("vec_gap_f_valid",  32'(f_valid),  32'h0);
            chk("vec_gap_f_signal", 32'(f_signal), 32'h0);
            n = 0;
            while (!m_valid && n < 3 * LAT) begin
                step();
                n++;
            end
            chk("vec_latency", 32'(n), 32'(LAT));
            chk("vec_m_out",   32'(m_out),   32'(tbl[v].exp_out));
            chk("vec_m_error", 32'(m_error), 32'(tbl[v].exp_err));
            step();
            chk("vec_no_dup", 32'(m_valid), 32'h0);
        end

        // 100-pair stream with m_ready high: in order, no gaps, s_ready stays 1.
        mon_en = 1'b1;
        recv_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            s_valid = 1'b1; s_signal = pair_sig(k); s_desired = pair_des(k);
            #1;
            chk("stream_s_ready", 32'(s_ready), 32'h1);
            step();
        end
        s_valid = 1'b0;
        wait_recv("stream_count", 100, 200);
        chk("stream_no_gaps", 32'(last_cyc - first_cyc), 32'd99);

        // Backpressure: credits stop issue after exactly DEPTH accepts.
        m_ready = 1'b0;
        acc_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            s_valid = 1'b1; s_signal = pair_sig(200 + k); s_desired = pair_des(200 + k);
            #1;
            chk("bp_s_ready", 32'(s_ready), (k < DEPTH) ? 32'h1 : 32'h0);
            step();
        end
        s_valid = 1'b0;
        chk("bp_accepts", 32'(acc_cnt), 32'(DEPTH));
        repeat (LAT + 2) step();
        chk("bp_m_valid", 32'(m_valid), 32'h1);
        chk("bp_ovf",     32'(ovf),     32'h0);
        chk("bp_s_ready_full", 32'(s_ready), 32'h0);
        held = {m_out, m_error};
        chk("bp_head", held, {pair_sig(200) + pair_des(200), pair_des(200) - pair_sig(200)});
        repeat (3) step();
        chk("bp_hold", {m_out, m_error}, held);
        base = recv_cnt;
        m_ready = 1'b1;
        wait_recv("bp_drain", base + DEPTH, 60);
        chk("bp_drained_m_valid", 32'(m_valid), 32'h0);
        chk("bp_drained_s_ready", 32'(s_ready), 32'h1);

        // 3*DEPTH transfers with a stuttering consumer: push/pop overlap near full.
        idx = 0;
        base = recv_cnt;
        for (int k = 0; k < 400 && idx < 3 * DEPTH; k++) begin
            m_ready = (k % 3) != 0;
            s_valid = 1'b1; s_signal = pair_sig(500 + idx); s_desired = pair_des(500 + idx);
            #1;
            hs = s_ready;
            step();
            if (hs) idx++;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        chk("wrap_issued", 32'(idx), 32'(3 * DEPTH));
        wait_recv("wrap_count", base + 3 * DEPTH, 100);
        chk("wrap_ovf", 32'(ovf), 32'h0);

        // Asynchronous reset between edges in the middle of a stream.
        for (int k = 0; k < 10; k++) begin
            s_valid = 1'b1; s_signal = pair_sig(800 + k); s_desired = pair_des(800 + k);
            step();
        end
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        reset = 1'b0;
        #1;
        chk("arst_m_valid", 32'(m_valid), 32'h0);
        chk("arst_m_out",   32'(m_out),   32'h0);
        chk("arst_s_ready", 32'(s_ready), 32'h1);
        chk("arst_f_valid", 32'(f_valid), 32'h0);
        chk("arst_ovf",     32'(ovf),     32'h0);
        exp_q.delete();
        repeat (2) step();
        s_valid = 1'b0;
        reset = 1'b1;
        step();
        mon_en = 1'b1;
        base = recv_cnt;
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1; s_signal = pair_sig(900 + k); s_desired = pair_des(900 + k);
            step();
        end
        s_valid = 1'b0;
        wait_recv("post_reset_count", base + 4, 40);
        repeat (3) step();
        chk("post_reset_extra", 32'(recv_cnt), 32'(base + 4));
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
